sync_fifo: RTL and testbench



---
 rtl/sync_fifo_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 80 ++++++++
 tb/tb_sync_fifo.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_pkg
// Description : Shared sizing constants for the systolic-array input-setup
//               FIFOs (word width, row depth and pointer width).
// Revision    : 1.0 - initial release
// ============================================================================
package sync_fifo_pkg;

  // Width of one operand word fed into the array
  localparam int DATA_SIZE = 8;

  // Number of MAC columns; sets the per-row delay-line depth
  localparam int MAC_WIDTH = 4;

  // Pointer width needed to address MAC_WIDTH entries
  localparam int ADDR_SIZE = $clog2(MAC_WIDTH);

endpackage : sync_fifo_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with registered read data and full/empty
//               flags. Used as a programmable delay line: once full, reading
//               and writing every cycle delays each word by DEPTH cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_SIZE,
  parameter int DEPTH      = MAC_WIDTH,
  parameter int ADDR_WIDTH = ADDR_SIZE
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam logic [ADDR_WIDTH:0]   c_DEPTH_CNT = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   c_CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_data_out;

  logic w_wr_acc;
  logic w_rd_acc;

  // A read frees a slot in the same cycle, so a full FIFO may still accept a
  // write when a read is accepted alongside it. An empty FIFO never reads,
  // even if a write arrives in the same cycle (no bypass path).
  assign w_rd_acc = rd_en && !empty;
  assign w_wr_acc = wr_en && (!full || rd_en);

  assign full     = (r_count == c_DEPTH_CNT);
  assign empty    = (r_count == '0);
  assign data_out = r_data_out;

  // Storage array: written on accept, never reset (stale data is unreachable)
  always_ff @(posedge clock) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // Pointers, occupancy and registered read data
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_data_out <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_rd_acc) begin
        r_rd_ptr   <= r_rd_ptr + c_PTR_ONE;
        r_data_out <= r_mem[r_rd_ptr];
      end
      if (w_wr_acc && !w_rd_acc) begin
        r_count <= r_count + c_CNT_ONE;
      end else if (w_rd_acc && !w_wr_acc) begin
        r_count <= r_count - c_CNT_ONE;
      end
    end
  end

endmodule : sync_fifo
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo
// Description : Self-checking bench for sync_fifo against a queue-based
//               reference model; directed cases followed by random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;

  localparam int DW = 8;
  localparam int DP = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [DW-1:0] data_in;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;

  int total = 0;
  int bad   = 0;

  // Reference model: contents in arrival order plus last value read out
  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_dout;

  sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DP), .ADDR_WIDTH(2)) dut (
    .clock   (clock),
    .reset   (reset),
    .data_in (data_in),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .data_out(data_out),
    .full    (full),
    .empty   (empty)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".data_out"}, {24'd0, data_out}, {24'd0, exp_dout});
    chk({tag, ".full"},     {31'd0, full},     {31'd0, (q.size() == DP)});
    chk({tag, ".empty"},    {31'd0, empty},    {31'd0, (q.size() == 0)});
  endtask

  // One clock cycle of traffic: drive on the falling edge, update the model
  // at the rising edge, then compare a little after it
  task automatic step(input logic wr, input logic rd, input logic [DW-1:0] d, input string tag);
    bit rd_ok;
    bit wr_ok;
    @(negedge clock);
    wr_en   = wr;
    rd_en   = rd;
    data_in = d;
    @(posedge clock);
    rd_ok = rd && (q.size() > 0);
    wr_ok = wr && ((q.size() < DP) || rd);
    if (rd_ok) exp_dout = q.pop_front();
    if (wr_ok) q.push_back(d);
    #1;
    chk_all(tag);
  endtask

  initial begin
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    data_in  = '0;
    exp_dout = '0;
    reset    = 1'b0;
    #1 reset = 1'b1;
    #1 chk_all("reset");
    @(negedge clock);
    reset = 1'b0;

    // Fill and drain
    step(1, 0, 8'h11, "fill0");
    step(1, 0, 8'h22, "fill1");
    step(1, 0, 8'h33, "fill2");
    step(1, 0, 8'h44, "fill3");
    chk("fill.full_now", {31'd0, full}, 32'd1);

    // Overflow: write without read while full is dropped
    step(1, 0, 8'h55, "ovf");
    step(0, 1, 8'h00, "drain0");
    chk("drain0.value", {24'd0, data_out}, 32'h11);
    step(0, 1, 8'h00, "drain1");
    step(0, 1, 8'h00, "drain2");
    step(0, 1, 8'h00, "drain3");
    chk("drain3.value", {24'd0, data_out}, 32'h44);

    // Underflow: reads on empty leave data_out unchanged
    for (int i = 0; i < 3; i++) step(0, 1, 8'hEE, "udf");
    chk("udf.hold", {24'd0, data_out}, 32'h44);

    // Delay line: fill with zeros, then read+write every cycle
    for (int i = 0; i < DP; i++) step(1, 0, 8'h00, "dl_fill");
    for (int i = 1; i <= 10; i++) begin
      step(1, 1, (i <= 6) ? 8'(i) : 8'h00, "dl_run");
      chk("dl_run.delay", {24'd0, data_out}, (i <= DP) ? 32'd0 : 32'(i - DP));
    end
    for (int i = 0; i < DP; i++) step(0, 1, 8'h00, "dl_drain");

    // Simultaneous read+write on empty: only the write is accepted
    step(1, 1, 8'h7A, "simul_empty");
    step(0, 1, 8'h00, "simul_read");
    chk("simul_read.value", {24'd0, data_out}, 32'h7A);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), "rand");
    end

    // Build occupancy with a nonzero output, then reset asynchronously mid-cycle
    step(1, 0, 8'hA5, "pre_rst_w0");
    step(1, 0, 8'h5A, "pre_rst_w1");
    step(0, 1, 8'h00, "pre_rst_r");
    @(negedge clock);
    wr_en = 1'b0;
    rd_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    q.delete();
    exp_dout = '0;
    chk_all("async_reset");
    @(negedge clock);
    reset = 1'b0;
    step(0, 1, 8'h00, "post_rst_read");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sync_fifo
`default_nettype wire
